// File: rtl/gcd_controller_pkg.sv
// Shared definitions for the subtractive GCD controller: state encoding and
// datapath mux/subtractor select constants.
package gcd_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMP  = 3'd1,
    ST_SUBX = 3'd2,
    ST_SUBY = 3'd3,
    ST_OUT  = 3'd4,
    ST_ERR  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  localparam logic SEL_EXT = 1'b0;
  localparam logic SEL_SUB = 1'b1;
  localparam logic SUB_XY  = 1'b0;
  localparam logic SUB_YX  = 1'b1;

endpackage

// File: rtl/gcd_controller_iter_cnt.sv
// Subtraction counter for the GCD controller: clears on a new run, counts
// subtraction steps and saturates at MAX_ITER so the watchdog sees a stable limit.
module gcd_controller_iter_cnt #(
  parameter int ITER_BITS = 5,
  parameter int MAX_ITER  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 inc_i,
  output logic [ITER_BITS-1:0] count_o,
  output logic                 at_max_o
);

  localparam logic [ITER_BITS-1:0] MaxVal = ITER_BITS'(MAX_ITER);

  logic [ITER_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MaxVal)) begin
      count_d = count_q + ITER_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == MaxVal);

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath: loads operands, steps
// compare/subtract from the status flags, strobes the result and holds done until ack.
module gcd_controller
  import gcd_controller_pkg::*;
#(
  parameter int ITER_BITS = 5,
  parameter int MAX_ITER  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic                 ack_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ITER_BITS-1:0] iter_o,
  input  logic                 xbig_i,
  input  logic                 ybig_i,
  input  logic                 eq_i,
  output logic                 sx_o,
  output logic                 sy_o,
  output logic                 ssub_o,
  output logic                 enx_o,
  output logic                 eny_o,
  output logic                 enobeb_o
);

  state_e state_q, state_d;
  logic   errFlag_q, errFlag_d;
  logic   ready_q, done_q, err_q, ssub_q, sx_q, sy_q, enx_q, eny_q, enobeb_q;
  logic   accept, atMax, iterInc;

  assign accept  = start_i & ready_q;
  assign iterInc = (state_q == ST_SUBX) || (state_q == ST_SUBY);

  gcd_controller_iter_cnt #(
    .ITER_BITS(ITER_BITS),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (accept),
    .inc_i   (iterInc),
    .count_o (iter_o),
    .at_max_o(atMax)
  );

  // The watchdog limit outranks eq so a run can never exceed MAX_ITER steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CMP;
      ST_CMP: begin
        if (atMax)       state_d = ST_ERR;
        else if (eq_i)   state_d = ST_OUT;
        else if (xbig_i) state_d = ST_SUBX;
        else if (ybig_i) state_d = ST_SUBY;
        else             state_d = ST_ERR;
      end
      ST_SUBX: state_d = ST_CMP;
      ST_SUBY: state_d = ST_CMP;
      ST_OUT:  state_d = ST_DONE;
      ST_ERR:  state_d = ST_DONE;
      ST_DONE: if (ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    errFlag_d = errFlag_q;
    if (accept) begin
      errFlag_d = 1'b0;
    end else if (state_q == ST_ERR) begin
      errFlag_d = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      errFlag_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ssub_q    <= SUB_XY;
      sx_q      <= SEL_EXT;
      sy_q      <= SEL_EXT;
      enx_q     <= 1'b0;
      eny_q     <= 1'b0;
      enobeb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      errFlag_q <= errFlag_d;
      ready_q   <= (state_d == ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      err_q     <= (state_d == ST_DONE) && errFlag_d;
      ssub_q    <= (state_d == ST_SUBY) ? SUB_YX : SUB_XY;
      sx_q      <= (state_d == ST_SUBX) ? SEL_SUB : SEL_EXT;
      sy_q      <= (state_d == ST_SUBY) ? SEL_SUB : SEL_EXT;
      enx_q     <= (state_d == ST_SUBX);
      eny_q     <= (state_d == ST_SUBY);
      enobeb_q  <= (state_d == ST_OUT);
    end
  end

  // Operand loads happen on the accept edge itself, so they bypass the registers.
  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign ssub_o   = ssub_q;
  assign sx_o     = sx_q;
  assign sy_o     = sy_q;
  assign enx_o    = enx_q | accept;
  assign eny_o    = eny_q | accept;
  assign enobeb_o = enobeb_q;

endmodule
